// File: rtl/ser_pkg.sv
// ser_pkg -- shared definitions for the bit_serializer slice.
//   SER_WIDTH_DEFAULT : default word length in bits
//   ser_state_e       : serializer FSM state encoding (IDLE, SHIFT)
//   ser_cnt_width()   : bit-counter width needed to hold WIDTH-1
package ser_pkg;

   localparam int unsigned SER_WIDTH_DEFAULT = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   function automatic int unsigned ser_cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter -- down-counter tracking the bits left in the current word.
//   clk    : clock, all updates on posedge
//   rst    : synchronous active-high reset, clears the count to 0
//   load_i : load WIDTH-1 (takes priority over en_i)
//   en_i   : decrement by one; holds at zero
//   zero_o : high when the count is zero
module ser_bit_counter
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic zero_o
);

   localparam int unsigned CW = ser_cnt_width(WIDTH);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(WIDTH - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer -- parallel-to-serial converter with valid/ready load handshake.
//   clk        : clock, all updates on posedge
//   rst        : synchronous active-high reset, aborts any word in progress
//   load_valid : load_data holds a word to send
//   load_data  : WIDTH-bit word to serialize
//   load_ready : word accepted this cycle when load_valid is also high
//   shift_en   : advance-one-bit strobe; low stalls the word in place
//   sout       : serial bit (0 while idle)
//   sout_valid : sout carries a word bit
//   done       : one-cycle pulse the cycle after the last bit is shifted out
// Build option: define BIT_SERIALIZER_LSB_FIRST_EN to send bit 0 first;
// otherwise bit WIDTH-1 goes first.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   ser_state_e       state_q;
   ser_state_e       state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic             done_q;
   logic             done_d;
   logic             cnt_zero;
   logic             last_bit;
   logic             advance;
   logic             accept;

   // Last bit leaves this cycle; a new word may be taken in the same cycle,
   // which keeps back-to-back words gapless.
   assign last_bit = (state_q == SHIFT) && shift_en && cnt_zero;
   assign advance  = (state_q == SHIFT) && shift_en && !cnt_zero;
   assign accept   = load_valid && load_ready;

   ser_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .en_i   (advance),
      .zero_o (cnt_zero)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_d = accept ? SHIFT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      load_ready = 1'b0;
      sout_valid = 1'b0;
      sout       = 1'b0;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
         end
         SHIFT: begin
            load_ready = last_bit;
            sout_valid = 1'b1;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
            sout       = shreg_q[0];
`else
            sout       = shreg_q[WIDTH-1];
`endif
         end
         default: begin
            load_ready = 1'b0;
         end
      endcase
   end

   // Shift register and done pulse
   always_comb begin
      shreg_d = shreg_q;
      if (accept) begin
         shreg_d = load_data;
      end else if (advance) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
         shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
         shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
      end
      done_d = last_bit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         done_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer -- directed and random checks of bit_serializer (WIDTH=8)
// against a queue-of-pending-bits reference model.
// Honours BIT_SERIALIZER_LSB_FIRST_EN for the expected bit order.
module tb_bit_serializer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic         shift_en;
   logic         sout;
   logic         sout_valid;
   logic         done;

   always #5 clk = ~clk;

   bit_serializer #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .shift_en   (shift_en),
      .sout       (sout),
      .sout_valid (sout_valid),
      .done       (done)
   );

   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          start    = 0;
   int          done_at  = -1;
   int          done_cnt = 0;
   int          capn     = 0;
   logic [31:0] cap      = '0;

   // Reference model: bits still to be sent, in transmit order, and the
   // registered done flag.
   bit mq[$];
   bit m_done = 1'b0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_capture();
      cap      = '0;
      capn     = 0;
      done_cnt = 0;
      done_at  = -1;
      start    = cyc;
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
   task automatic step(input logic r, input logic lv, input logic [W-1:0] d,
                       input logic se);
      logic exp_valid;
      logic exp_sout;
      logic exp_ready;
      bit   acc;
      rst        = r;
      load_valid = lv;
      load_data  = d;
      shift_en   = se;
      @(negedge clk);
      exp_valid = (mq.size() != 0);
      exp_sout  = exp_valid ? mq[0] : 1'b0;
      exp_ready = !exp_valid || (mq.size() == 1 && se);
      chk("sout_valid", sout_valid, exp_valid);
      chk("sout", sout, exp_sout);
      chk("load_ready", load_ready, exp_ready);
      chk("done", done, m_done);
      if (sout_valid === 1'b1) begin
         cap = {cap[30:0], sout};
         capn++;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_at = cyc;
      end
      if (r) begin
         mq.delete();
         m_done = 1'b0;
      end else begin
         acc    = lv && exp_ready;
         m_done = exp_valid && se && (mq.size() == 1);
         if (exp_valid && se) void'(mq.pop_front());
         if (acc) begin
            for (int i = 0; i < W; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
               mq.push_back(d[i]);
`else
               mq.push_back(d[W-1-i]);
`endif
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      shift_en   = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_sout", sout, 1'b0);
      chk("rst_sout_valid", sout_valid, 1'b0);
      chk("rst_load_ready", load_ready, 1'b1);
      chk("rst_done", done, 1'b0);

      // Single word 8'h99, continuous shift
      clear_capture();
      step(1'b0, 1'b1, 8'h99, 1'b1);
      repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_int("w99_bits", int'(cap[7:0]), 32'h99);
      chk_int("w99_count", capn, 8);
      chk_int("w99_done_cycle", done_at - start, 9);
      chk_int("w99_done_pulses", done_cnt, 1);

      // Back-to-back 8'h90 then 8'h09 held valid
      clear_capture();
      step(1'b0, 1'b1, 8'h90, 1'b1);
      repeat (8) step(1'b0, 1'b1, 8'h09, 1'b1);
      repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      chk_int("b2b_bits", int'(cap[15:0]), 32'h0990);
`else
      chk_int("b2b_bits", int'(cap[15:0]), 32'h9009);
`endif
      chk_int("b2b_count", capn, 16);
      chk_int("b2b_done_pulses", done_cnt, 2);
      chk_int("b2b_last_done", done_at - start, 17);

      // 8'hA5 stalled for 3 cycles while the 2nd bit is on sout
      clear_capture();
      step(1'b0, 1'b1, 8'hA5, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
      repeat (9) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_int("stall_bits", int'(cap[10:0]), 32'h425);
      chk_int("stall_count", capn, 11);
      chk_int("stall_done_cycle", done_at - start, 12);

      // Reset while the 4th bit of 8'hFF is on sout
      clear_capture();
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk("abort_sout", sout, 1'b0);
      chk("abort_sout_valid", sout_valid, 1'b0);
      chk("abort_load_ready", load_ready, 1'b1);
      repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_int("abort_no_done", done_cnt, 0);
      chk_int("abort_count", capn, 4);

      // Load attempt of 8'h3C mid-word is ignored
      clear_capture();
      step(1'b0, 1'b1, 8'hC3, 1'b1);
      repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h3C, 1'b1);
      repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_int("ignore_bits", int'(cap[7:0]), 32'hC3);
      chk_int("ignore_count", capn, 8);
      chk_int("ignore_done_pulses", done_cnt, 1);

      // Bit order on an asymmetric word
      clear_capture();
      step(1'b0, 1'b1, 8'h01, 1'b1);
      repeat (9) step(1'b0, 1'b0, 8'h00, 1'b1);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      chk_int("order_bits", int'(cap[7:0]), 32'h80);
`else
      chk_int("order_bits", int'(cap[7:0]), 32'h01);
`endif

      // Random traffic
      repeat (500) begin
         step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              8'($urandom),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
